// File: rtl/fetch_buffer_if.sv
// Handshake bundle between PC logic, instruction memory and decoder for fetch_buffer.
// The master modport is the fetch buffer side; slave is the surrounding core/memory.
interface fetch_buffer_if #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH + 1);

    logic            redirect;
    logic [XLEN-1:0] redirect_pc;
    logic            halt;
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ack;
    logic [31:0]     imem_rdata;
    logic            inst_valid;
    logic [31:0]     inst;
    logic [XLEN-1:0] inst_pc;
    logic            inst_ready;
    logic [CW-1:0]   count;

    modport master (
        input  redirect, redirect_pc, halt, imem_ack, imem_rdata, inst_ready,
        output imem_req, imem_addr, inst_valid, inst, inst_pc, count
    );

    modport slave (
        output redirect, redirect_pc, halt, imem_ack, imem_rdata, inst_ready,
        input  imem_req, imem_addr, inst_valid, inst, inst_pc, count
    );
endinterface

// File: rtl/fetch_buffer.sv
// Instruction-fetch front end: one-outstanding handshaked memory request feeding a prefetch FIFO.
// Optional same-cycle bypass of an acked word when the FIFO is empty: define FETCH_BYPASS_EN.
module fetch_buffer #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(32'h0000_0000)
) (
    input  logic           sysclk,
    input  logic           cpu_resetn,
    fetch_buffer_if.master bus
);
    localparam int            PW      = $clog2(DEPTH);
    localparam int            CW      = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DROP = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [PW-1:0]   head_q, head_d;
    logic [PW-1:0]   tail_q, tail_d;
    logic [CW-1:0]   count_q, count_d;
    logic [31:0]     mem_inst_q [DEPTH];
    logic [31:0]     mem_inst_d [DEPTH];
    logic [XLEN-1:0] mem_pc_q [DEPTH];
    logic [XLEN-1:0] mem_pc_d [DEPTH];

    logic            req_s;
    logic [XLEN-1:0] addr_s;
    logic            push_s;
    logic            store_s;
    logic            pop_s;
    logic            unused_rpc_s;

    assign unused_rpc_s = ^bus.redirect_pc[1:0];

    // Request outputs; REQ/DROP replay the latched address so it is stable until ack.
    always_comb begin
        req_s  = 1'b0;
        addr_s = fetch_pc_q;
        case (state_q)
            S_IDLE: begin
                req_s  = cpu_resetn & ~bus.halt & ~bus.redirect & (count_q < DEPTH_C);
                addr_s = fetch_pc_q;
            end
            S_REQ, S_DROP: begin
                req_s  = 1'b1;
                addr_s = addr_q;
            end
            default: begin
                req_s  = 1'b0;
                addr_s = fetch_pc_q;
            end
        endcase
    end

    // Fetch FSM next state, fetch PC and push decision.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        addr_d     = addr_q;
        push_s     = 1'b0;
        if (bus.redirect) begin
            fetch_pc_d = {bus.redirect_pc[XLEN-1:2], 2'b00};
            if ((state_q == S_REQ || state_q == S_DROP) && !bus.imem_ack) begin
                state_d = S_DROP;
            end else begin
                state_d = S_IDLE;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_s) begin
                        addr_d = fetch_pc_q;
                        if (bus.imem_ack) begin
                            push_s     = 1'b1;
                            fetch_pc_d = fetch_pc_q + XLEN'(4);
                        end else begin
                            state_d = S_REQ;
                        end
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_REQ: begin
                    if (bus.imem_ack) begin
                        push_s     = 1'b1;
                        fetch_pc_d = fetch_pc_q + XLEN'(4);
                        state_d    = S_IDLE;
                    end else begin
                        state_d = S_REQ;
                    end
                end
                S_DROP: begin
                    if (bus.imem_ack) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_DROP;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

`ifdef FETCH_BYPASS_EN
    logic byp_s;
    assign byp_s   = (count_q == CW'(0)) & (state_q != S_DROP) & ~bus.redirect & req_s & bus.imem_ack;
    // A bypassed word consumed in the same cycle never occupies a slot.
    assign store_s = push_s & ~(byp_s & bus.inst_ready);
    assign bus.inst_valid = (count_q != CW'(0)) | byp_s;
    assign bus.inst       = byp_s ? bus.imem_rdata : mem_inst_q[head_q];
    assign bus.inst_pc    = byp_s ? addr_s : mem_pc_q[head_q];
`else
    assign store_s        = push_s;
    assign bus.inst_valid = (count_q != CW'(0));
    assign bus.inst       = mem_inst_q[head_q];
    assign bus.inst_pc    = mem_pc_q[head_q];
`endif

    assign pop_s         = (count_q != CW'(0)) & bus.inst_ready & ~bus.redirect;
    assign bus.imem_req  = req_s;
    assign bus.imem_addr = addr_s;
    assign bus.count     = count_q;

    // FIFO pointers and storage; a flush keeps head so the output word holds.
    always_comb begin
        mem_inst_d = mem_inst_q;
        mem_pc_d   = mem_pc_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        if (bus.redirect) begin
            tail_d  = head_q;
            count_d = CW'(0);
        end else begin
            if (store_s) begin
                mem_inst_d[tail_q] = bus.imem_rdata;
                mem_pc_d[tail_q]   = fetch_pc_q;
                tail_d             = tail_q + PW'(1);
            end else begin
                tail_d = tail_q;
            end
            if (pop_s) begin
                head_d = head_q + PW'(1);
            end else begin
                head_d = head_q;
            end
            count_d = count_q + CW'(store_s) - CW'(pop_s);
        end
    end

    // State registers.
    always_ff @(posedge sysclk or negedge cpu_resetn) begin
        if (!cpu_resetn) begin
            state_q    <= S_IDLE;
            fetch_pc_q <= RESET_PC;
            addr_q     <= RESET_PC;
            head_q     <= PW'(0);
            tail_q     <= PW'(0);
            count_q    <= CW'(0);
            for (int i = 0; i < DEPTH; i++) begin
                mem_inst_q[i] <= 32'h0000_0000;
                mem_pc_q[i]   <= XLEN'(0);
            end
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            addr_q     <= addr_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            mem_inst_q <= mem_inst_d;
            mem_pc_q   <= mem_pc_d;
        end
    end
endmodule

// File: tb/tb_fetch_buffer.sv
// Directed, table-driven bench for fetch_buffer (XLEN=32, DEPTH=4, RESET_PC=0, bypass off).
// Inputs change on the falling edge; outputs are compared 1 ns later, before the next rising edge.
module tb_fetch_buffer;
    logic sysclk;
    logic cpu_resetn;

    fetch_buffer_if #(.XLEN(32), .DEPTH(4)) bus ();

    fetch_buffer #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
        .sysclk    (sysclk),
        .cpu_resetn(cpu_resetn),
        .bus       (bus)
    );

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    typedef struct {
        bit          rst;
        bit          redir;
        logic [31:0] rpc;
        bit          halt;
        bit          ack;
        logic [31:0] rd;
        bit          rdy;
        bit          e_req;
        bit          c_addr;
        logic [31:0] e_addr;
        bit          e_val;
        logic [31:0] e_pc;
        logic [31:0] e_inst;
        int          e_cnt;
    } vec_t;

    int   checks;
    int   errors;
    vec_t vecs[$];

    function automatic vec_t mk(bit rst, bit redir, logic [31:0] rpc, bit halt, bit ack,
                                logic [31:0] rd, bit rdy, bit e_req, bit c_addr,
                                logic [31:0] e_addr, bit e_val, logic [31:0] e_pc,
                                logic [31:0] e_inst, int e_cnt);
        vec_t v;
        v.rst = rst; v.redir = redir; v.rpc = rpc; v.halt = halt; v.ack = ack;
        v.rd = rd; v.rdy = rdy; v.e_req = e_req; v.c_addr = c_addr; v.e_addr = e_addr;
        v.e_val = e_val; v.e_pc = e_pc; v.e_inst = e_inst; v.e_cnt = e_cnt;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row %0d: got 0x%08h, expected 0x%08h", name, idx, act, exp);
        end
    endtask

    task automatic step(input vec_t v, input int idx);
        @(negedge sysclk);
        cpu_resetn      = ~v.rst;
        bus.redirect    = v.redir;
        bus.redirect_pc = v.rpc;
        bus.halt        = v.halt;
        bus.imem_ack    = v.ack;
        bus.imem_rdata  = v.rd;
        bus.inst_ready  = v.rdy;
        #1;
        chk("imem_req", idx, 32'(bus.imem_req), 32'(v.e_req));
        if (v.c_addr) chk("imem_addr", idx, bus.imem_addr, v.e_addr);
        chk("inst_valid", idx, 32'(bus.inst_valid), 32'(v.e_val));
        if (v.e_val || v.rst) begin
            chk("inst_pc", idx, bus.inst_pc, v.e_pc);
            chk("inst", idx, bus.inst, v.e_inst);
        end
        chk("count", idx, 32'(bus.count), 32'(v.e_cnt));
    endtask

    initial begin
        checks          = 0;
        errors          = 0;
        cpu_resetn      = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 32'h0000_0000;
        bus.halt        = 1'b0;
        bus.imem_ack    = 1'b0;
        bus.imem_rdata  = 32'h0000_0000;
        bus.inst_ready  = 1'b0;

        // rst redir rpc halt ack rdata rdy | req chkA addr valid pc inst count
        // Reset, then zero-wait streaming with the consumer always ready.
        vecs.push_back(mk(1,0,32'h0,0,0,32'h0,1,        0,0,32'h0,0,32'h0,32'h0,0));
        vecs.push_back(mk(0,0,32'h0,0,1,32'hDA00_0000,1, 1,1,32'h0,0,32'h0,32'h0,0));
        vecs.push_back(mk(0,0,32'h0,0,1,32'hDA00_0004,1, 1,1,32'h4,1,32'h0,32'hDA00_0000,1));
        vecs.push_back(mk(0,0,32'h0,0,1,32'hDA00_0008,1, 1,1,32'h8,1,32'h4,32'hDA00_0004,1));
        vecs.push_back(mk(0,0,32'h0,1,0,32'h0,1,        0,1,32'hC,1,32'h8,32'hDA00_0008,1));
        // Reset, fill to DEPTH with the consumer stalled, then drain in order.
        vecs.push_back(mk(1,0,32'h0,0,0,32'h0,0,        0,0,32'h0,0,32'h0,32'h0,0));
        vecs.push_back(mk(0,0,32'h0,0,1,32'hDA00_0000,0, 1,1,32'h0,0,32'h0,32'h0,0));
        vecs.push_back(mk(0,0,32'h0,0,1,32'hDA00_0004,0, 1,1,32'h4,1,32'h0,32'hDA00_0000,1));
        vecs.push_back(mk(0,0,32'h0,0,1,32'hDA00_0008,0, 1,1,32'h8,1,32'h0,32'hDA00_0000,2));
        vecs.push_back(mk(0,0,32'h0,0,1,32'hDA00_000C,0, 1,1,32'hC,1,32'h0,32'hDA00_0000,3));
        vecs.push_back(mk(0,0,32'h0,0,1,32'hEEEE_EEEE,0, 0,1,32'h10,1,32'h0,32'hDA00_0000,4));
        vecs.push_back(mk(0,0,32'h0,0,0,32'h0,1,        0,1,32'h10,1,32'h0,32'hDA00_0000,4));
        vecs.push_back(mk(0,0,32'h0,1,0,32'h0,1,        0,1,32'h10,1,32'h4,32'hDA00_0004,3));
        vecs.push_back(mk(0,0,32'h0,1,0,32'h0,1,        0,1,32'h10,1,32'h8,32'hDA00_0008,2));
        vecs.push_back(mk(0,0,32'h0,1,0,32'h0,1,        0,1,32'h10,1,32'hC,32'hDA00_000C,1));
        vecs.push_back(mk(0,0,32'h0,1,0,32'h0,1,        0,1,32'h10,0,32'h0,32'h0,0));
        // Slow memory; redirect to 0x103 mid-wait turns the request into a drop.
        vecs.push_back(mk(0,0,32'h0,0,0,32'h0,1,        1,1,32'h10,0,32'h0,32'h0,0));
        vecs.push_back(mk(0,0,32'h0,0,0,32'h0,1,        1,1,32'h10,0,32'h0,32'h0,0));
        vecs.push_back(mk(0,1,32'h103,0,0,32'h0,1,      1,1,32'h10,0,32'h0,32'h0,0));
        vecs.push_back(mk(0,0,32'h0,0,0,32'h0,1,        1,1,32'h10,0,32'h0,32'h0,0));
        vecs.push_back(mk(0,0,32'h0,0,1,32'hDEAD_BEEF,1, 1,1,32'h10,0,32'h0,32'h0,0));
        vecs.push_back(mk(0,0,32'h0,0,1,32'hDA00_0100,0, 1,1,32'h100,0,32'h0,32'h0,0));
        // Redirect to 0x200 together with ack and pop.
        vecs.push_back(mk(0,0,32'h0,0,0,32'h0,0,        1,1,32'h104,1,32'h100,32'hDA00_0100,1));
        vecs.push_back(mk(0,1,32'h200,0,1,32'hBAD0_0000,1, 1,1,32'h104,1,32'h100,32'hDA00_0100,1));
        vecs.push_back(mk(0,0,32'h0,0,0,32'h0,1,        1,1,32'h200,0,32'h0,32'h0,0));
        // halt while a request is outstanding.
        vecs.push_back(mk(0,0,32'h0,1,0,32'h0,0,        1,1,32'h200,0,32'h0,32'h0,0));
        vecs.push_back(mk(0,0,32'h0,1,1,32'hDA00_0200,0, 1,1,32'h200,0,32'h0,32'h0,0));
        vecs.push_back(mk(0,0,32'h0,1,0,32'h0,0,        0,1,32'h204,1,32'h200,32'hDA00_0200,1));
        vecs.push_back(mk(0,0,32'h0,1,1,32'hEEEE_EEEE,0, 0,1,32'h204,1,32'h200,32'hDA00_0200,1));
        vecs.push_back(mk(0,0,32'h0,0,1,32'hDA00_0204,1, 1,1,32'h204,1,32'h200,32'hDA00_0200,1));
        vecs.push_back(mk(0,0,32'h0,0,0,32'h0,1,        1,1,32'h208,1,32'h204,32'hDA00_0204,1));
        // Redirect to the top of the address space and wrap to zero.
        vecs.push_back(mk(0,1,32'hFFFF_FFFC,0,1,32'hBAD0_0000,1, 1,1,32'h208,0,32'h0,32'h0,0));
        vecs.push_back(mk(0,0,32'h0,0,1,32'hDA00_FFFC,1, 1,1,32'hFFFF_FFFC,0,32'h0,32'h0,0));
        vecs.push_back(mk(0,0,32'h0,0,1,32'hDB00_0000,1, 1,1,32'h0,1,32'hFFFF_FFFC,32'hDA00_FFFC,1));
        vecs.push_back(mk(0,0,32'h0,1,0,32'h0,1,        0,1,32'h4,1,32'h0,32'hDB00_0000,1));
        vecs.push_back(mk(0,0,32'h0,1,0,32'h0,1,        0,1,32'h4,0,32'h0,32'h0,0));

        foreach (vecs[i]) step(vecs[i], i);

        // Redirects while dropping: address stays stale, the last redirect target wins.
        step(mk(0,0,32'h0,0,0,32'h0,1,        1,1,32'h4,0,32'h0,32'h0,0), 100);
        step(mk(0,1,32'h300,0,0,32'h0,1,      1,1,32'h4,0,32'h0,32'h0,0), 101);
        step(mk(0,1,32'h405,0,0,32'h0,1,      1,1,32'h4,0,32'h0,32'h0,0), 102);
        step(mk(0,0,32'h0,0,1,32'hDEAD_BEEF,1, 1,1,32'h4,0,32'h0,32'h0,0), 103);
        step(mk(0,0,32'h0,0,1,32'hDA00_0404,0, 1,1,32'h404,0,32'h0,32'h0,0), 104);
        step(mk(0,0,32'h0,1,0,32'h0,0,        0,1,32'h408,1,32'h404,32'hDA00_0404,1), 105);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fetch_buffer.md
Name: fetch_buffer

Overview:
- Parametrised instruction-fetch front end that sits between the PC logic and the decoder.
- Replaces the combinational PC-to-instruction-memory path with a handshaked, variable-latency memory request and a prefetch FIFO.
- Each FIFO entry holds an {instruction, PC} pair.
- Supports branch/jump redirect with flush, and a halt input.

Parameters:
- XLEN, 32, address/PC width.
- DEPTH, 4, FIFO entries; power of two, ≥2.
- RESET_PC, 32'h0000_0000, first fetch address after reset; low 2 bits must be zero.

Ports:
- sysclk  in  1  clock.
- cpu_resetn  in  1  asynchronous active-low reset.
- redirect  in  1  pulse: flush and restart fetch at redirect_pc.
- redirect_pc  in  XLEN  new fetch address; bits [1:0] are ignored and treated as 0.
- halt  in  1  level: stop issuing new requests.
- imem_req  out  1  request to instruction memory.
- imem_addr  out  XLEN  request address.
- imem_ack  in  1  memory returns data this cycle.
- imem_rdata  in  32  instruction word, valid with imem_ack.
- inst_valid  out  1  FIFO head valid.
- inst  out  32  head instruction.
- inst_pc  out  XLEN  head PC.
- inst_ready  in  1  consumer pops head when inst_valid & inst_ready.
- count  out  $clog2(DEPTH+1)  occupied entries.

Behaviour:
- Reset is asynchronous, active-low. On reset:
  - fetch_pc = RESET_PC; state = IDLE; FIFO empty.
  - imem_req = 0, inst_valid = 0, inst = 0, inst_pc = 0, count = 0.
- Only one outstanding memory request at a time.
- Memory handshake:
  - imem_req and imem_addr stay stable from assertion until the cycle imem_ack = 1.
  - ack may arrive in the same cycle as req (zero wait).
  - imem_ack while imem_req = 0 is ignored.
- State IDLE:
  - imem_req = !halt & !redirect & (count < DEPTH); imem_addr = fetch_pc.
  - If the request is asserted and imem_ack = 0 → REQ. If asserted with imem_ack = 1 → push, and stay in IDLE.
- State REQ:
  - imem_req = 1.
  - On imem_ack: push {imem_rdata, fetch_pc}; fetch_pc += 4 (wraps modulo 2^XLEN); → IDLE.
  - halt does not cancel a request already in REQ.
- State DROP:
  - imem_req = 1 with the stale address.
  - On imem_ack: data discarded, no push, fetch_pc unchanged; → IDLE.
- Redirect (any state, highest priority):
  - FIFO flushed (count = 0 next cycle); fetch_pc = {redirect_pc[XLEN-1:2], 2'b00}.
  - A pop in the same cycle is void. Data acked in the same cycle is discarded.
  - If in REQ and imem_ack = 0 → DROP; otherwise → IDLE.
  - Redirect while in DROP: stay in DROP and update fetch_pc.
- Slot reservation:
  - A request issues only when count < DEPTH.
  - The FIFO therefore can never overflow on ack; a push into a full FIFO is impossible by construction.
- Push and pop in the same cycle: count unchanged; both take effect.
- Pop with inst_valid = 0 is ignored.
- Latency: ack at cycle t → inst_valid = 1 at t+1 when the FIFO was empty (without the optional feature).
- FIFO ordering:
  - Head and tail pointers are $clog2(DEPTH) bits and wrap naturally.
  - inst and inst_pc hold their last value when empty; only inst_valid is meaningful.
- halt:
  - Blocks new requests only; the FIFO keeps draining.
  - Deasserting halt resumes at fetch_pc.

Optional Feature:
- Macro: FETCH_BYPASS_EN.
- Defined:
  - When the FIFO is empty, state ≠ DROP, redirect = 0 and imem_ack = 1, then inst_valid = 1 in the same cycle, with inst = imem_rdata and inst_pc = imem_addr.
  - If inst_ready is also 1, the word is consumed and not written to the FIFO (count stays 0).
  - Otherwise it is pushed as normal.
- Undefined: no combinational path from imem_* to inst_*; minimum latency is 1 cycle.

Test Plan:
- Reset, then release with zero-wait memory (ack = req) and inst_ready = 1:
  - imem_addr sequence 0x0, 0x4, 0x8.
  - inst_pc at the output follows 1 cycle later (bypass off) / same cycle (bypass on).
- inst_ready = 0 with zero-wait memory and DEPTH = 4:
  - Exactly 4 pushes; count = 4; imem_req = 0; fetch_pc = 0x10.
  - Raise inst_ready: entries 0x0–0xC are popped in order.
- Memory latency 3 cycles; redirect to 0x103 during the 2nd wait cycle:
  - State goes to DROP; stale ack is discarded; count = 0.
  - Next request address is 0x100.
- Redirect to 0x200 in the same cycle as ack and pop:
  - The acked word is not pushed; count = 0 next cycle.
  - Next imem_addr = 0x200.
- halt = 1 while REQ is outstanding:
  - The ack completes and is pushed; no further imem_req while halt is high.
  - Release halt: fetch resumes at the next sequential PC.
- redirect_pc = 0xFFFF_FFFC with XLEN = 32:
  - Fetches 0xFFFF_FFFC, then 0x0000_0000 (wrap-around).
